// File: rtl/tse_phy_mon_pkg.sv
// Shared types and constants for the 88E1111 link monitor: FSM states, the Clause-22
// read frame layout, and the bit positions in the PHY-specific status register.
package tse_phy_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        DECODE = 2'd2
    } state_t;

    localparam logic [1:0] ST      = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    localparam logic [5:0] TA_START   = 6'd46;
    localparam logic [5:0] TA_SAMPLE  = 6'd47;
    localparam logic [5:0] DATA_START = 6'd48;
    localparam logic [5:0] LAST_BIT   = 6'd63;

    localparam int SPEED_HI = 15;
    localparam int DUPLEX   = 13;
    localparam int RESOLVED = 11;
    localparam int LINK     = 10;

    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_10   = 2'b00;

    // Whole read frame, bit 0 of the frame in position 63; TA and data slots are left at 1
    // because the master has released the line by then.
    function automatic logic [63:0] read_frame(input logic [4:0] phy_addr,
                                               input logic [4:0] reg_addr);
        return {32'hFFFF_FFFF, ST, OP_READ, phy_addr, reg_addr, 18'h3FFFF};
    endfunction

endpackage

// File: rtl/tse_phy_link_monitor_mdio_clk_gen.sv
// MDC divider: low and high phases of CLK_DIV cycles each while enabled, held low otherwise.
// rise_tick/fall_tick flag the cycle whose closing edge flips mdc.
module mdio_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    output logic mdc,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          mdc_reg;
    logic          phase_end;

    assign phase_end = en && (cnt_reg == CNT_LAST);
    assign rise_tick = phase_end && !mdc_reg;
    assign fall_tick = phase_end && mdc_reg;
    assign mdc       = mdc_reg;

    always_ff @(posedge clk) begin
        if (srst || !en) begin
            cnt_reg <= '0;
            mdc_reg <= 1'b0;
        end else if (phase_end) begin
            cnt_reg <= '0;
            mdc_reg <= ~mdc_reg;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/tse_phy_link_monitor.sv
// Polls the 88E1111 PHY-specific status register over MDIO and steers the TSE MAC
// set_10/set_1000 inputs from the resolved speed.
module tse_phy_link_monitor #(
    parameter int         CLK_DIV     = 25,
    parameter logic [4:0] PHY_ADDR    = 5'd16,
    parameter logic [4:0] STATUS_REG  = 5'd17,
    parameter int         POLL_CYCLES = 50_000_000
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic poll_now,
    output logic mdc,
    input  logic mdio_in,
    output logic mdio_out,
    output logic mdio_oen,
    output logic set_10,
    output logic set_1000,
    output logic link_up,
    output logic full_duplex,
    output logic status_valid,
    output logic rd_err,
    output logic busy
);

    import tse_phy_mon_pkg::*;

    localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
    localparam logic [63:0]   FRAME_WORD = read_frame(PHY_ADDR, STATUS_REG);

    state_t        state_reg, state_next;
    logic          start_frame;
    logic [TW-1:0] timer_reg;
    logic          pending_reg;
    logic [5:0]    bit_idx_reg;
    logic [5:0]    bit_idx_next;
    logic [15:0]   shift_reg;
    logic          ta_fail_reg;
    logic          mdio_out_reg, mdio_oen_reg;
    logic          set_10_reg, set_1000_reg, link_up_reg, full_duplex_reg;
    logic          status_valid_reg, rd_err_reg;
    logic          rise_tick, fall_tick;
    logic [1:0]    speed;
    logic          reserved_speed;

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk_clk),
        .srst      (reset_reset),
        .en        (state_reg == FRAME),
        .mdc       (mdc),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign bit_idx_next   = bit_idx_reg + 6'd1;
    assign speed          = shift_reg[SPEED_HI -: 2];
    assign reserved_speed = shift_reg[RESOLVED] && (speed == 2'b11);

    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        case (state_reg)
            IDLE: begin
                if (poll_now || pending_reg || (timer_reg == TIMER_LAST)) begin
                    start_frame = 1'b1;
                    state_next  = FRAME;
                end
            end
            FRAME:   if (fall_tick && (bit_idx_reg == LAST_BIT)) state_next = DECODE;
            DECODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // pending_reg resets to 1 so the first read goes out right after reset releases.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg        <= IDLE;
            timer_reg        <= '0;
            pending_reg      <= 1'b1;
            bit_idx_reg      <= '0;
            shift_reg        <= '0;
            ta_fail_reg      <= 1'b0;
            mdio_out_reg     <= 1'b1;
            mdio_oen_reg     <= 1'b1;
            set_10_reg       <= 1'b0;
            set_1000_reg     <= 1'b1;
            link_up_reg      <= 1'b0;
            full_duplex_reg  <= 1'b0;
            status_valid_reg <= 1'b0;
            rd_err_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            status_valid_reg <= 1'b0;
            rd_err_reg       <= 1'b0;

            if (start_frame)
                pending_reg <= 1'b0;
            else if (poll_now && (state_reg != IDLE))
                pending_reg <= 1'b1;

            if ((state_reg == IDLE) && !start_frame)
                timer_reg <= timer_reg + TW'(1);
            else
                timer_reg <= '0;

            case (state_reg)
                IDLE: begin
                    if (start_frame) begin
                        bit_idx_reg  <= '0;
                        ta_fail_reg  <= 1'b0;
                        mdio_out_reg <= FRAME_WORD[63];
                        mdio_oen_reg <= 1'b0;
                    end
                end
                FRAME: begin
                    if (rise_tick) begin
                        if (bit_idx_reg == TA_SAMPLE)
                            ta_fail_reg <= mdio_in;
                        if (bit_idx_reg >= DATA_START)
                            shift_reg <= {shift_reg[14:0], mdio_in};
                    end
                    // New bit is presented at the start of each low phase.
                    if (fall_tick) begin
                        if (bit_idx_reg == LAST_BIT) begin
                            mdio_out_reg <= 1'b1;
                            mdio_oen_reg <= 1'b1;
                        end else begin
                            bit_idx_reg  <= bit_idx_next;
                            mdio_out_reg <= FRAME_WORD[~bit_idx_next];
                            mdio_oen_reg <= (bit_idx_next >= TA_START);
                        end
                    end
                end
                DECODE: begin
                    if (ta_fail_reg || reserved_speed) begin
                        rd_err_reg <= 1'b1;
                    end else begin
                        status_valid_reg <= 1'b1;
                        link_up_reg      <= shift_reg[LINK];
                        // Unresolved results leave speed and duplex at the last resolved values.
                        if (shift_reg[RESOLVED]) begin
                            full_duplex_reg <= shift_reg[DUPLEX];
                            case (speed)
                                SPD_1000: begin set_1000_reg <= 1'b1; set_10_reg <= 1'b0; end
                                SPD_100:  begin set_1000_reg <= 1'b0; set_10_reg <= 1'b0; end
                                SPD_10:   begin set_1000_reg <= 1'b0; set_10_reg <= 1'b1; end
                                default:  ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdio_out     = mdio_out_reg;
    assign mdio_oen     = mdio_oen_reg;
    assign set_10       = set_10_reg;
    assign set_1000     = set_1000_reg;
    assign link_up      = link_up_reg;
    assign full_duplex  = full_duplex_reg;
    assign status_valid = status_valid_reg;
    assign rd_err       = rd_err_reg;
    assign busy         = (state_reg != IDLE);

endmodule
